dev_bus_arbiter: RTL and testbench

- Shares the peripheral device bus (ADC, DAC, switch matrix, timer) between two requesters:
  - req0: the memory-block sequencer.
  - req1: the host direct-command path.
- Per transaction it grants one requester, pulses the selected device chip-select, waits for that device's ready, then reports done/error.
- Sits between the sequencer / host command decoder and the device driver blocks.
- Owns all four *_cs lines.

---
 rtl/dev_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dev_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_bus_arbiter.sv
// Round-robin owner of the ADC/DAC/switch/timer chip-selects shared by the sequencer (req0) and host (req1).
// Optional ARB_LOCK_EN: adds req0_lock so req0 can keep priority across back-to-back grants.

module dev_bus_arbiter #(
   parameter int unsigned CS_WIDTH       = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [3:0] req0_dev,
`ifdef ARB_LOCK_EN
   input  logic       req0_lock,
`endif
   output logic       req0_ack,
   output logic       req0_done,
   output logic       req0_err,
   input  logic       req1_valid,
   input  logic [3:0] req1_dev,
   output logic       req1_ack,
   output logic       req1_done,
   output logic       req1_err,
   output logic       adc_cs,
   output logic       dac_cs,
   output logic       switch_cs,
   output logic       timer_cs,
   input  logic       adc_rdy,
   input  logic       dac_rdy,
   input  logic       switch_rdy,
   input  logic       timer_rdy,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS,
      ST_GUARD,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic [3:0]  CS_LAST = 4'(CS_WIDTH - 1);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic        ptr_q;
   logic        gnt_q;
   logic [3:0]  sel_q;
   logic [3:0]  cs_q;
   logic [3:0]  cs_cnt_q;
   logic [15:0] to_cnt_q;
   logic        ack0_q, done0_q, err0_q;
   logic        ack1_q, done1_q, err1_q;
   logic        busy_q;

   logic        gnt_vld_d;
   logic        gnt_id_d;
   logic        ptr_d;
   logic [3:0]  gnt_dev_d;
   logic [3:0]  sel_d;
   logic        rdy_sel;

   // Pointer names the requester that wins a tie; the winner hands priority to the other side.
   always_comb begin
      gnt_vld_d = 1'b0;
      gnt_id_d  = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_vld_d = 1'b1;
         gnt_id_d  = ptr_q;
      end else if (req0_valid) begin
         gnt_vld_d = 1'b1;
         gnt_id_d  = 1'b0;
      end else if (req1_valid) begin
         gnt_vld_d = 1'b1;
         gnt_id_d  = 1'b1;
      end

      gnt_dev_d = gnt_id_d ? req1_dev : req0_dev;
      ptr_d     = ~gnt_id_d;
`ifdef ARB_LOCK_EN
      if (!gnt_id_d && req0_lock) begin
         ptr_d = 1'b0;
      end
`endif

      case (gnt_dev_d)
         4'd1:    sel_d = 4'b0001;
         4'd2:    sel_d = 4'b0010;
         4'd3:    sel_d = 4'b0100;
         4'd4:    sel_d = 4'b1000;
         default: sel_d = 4'b0000;
      endcase
   end

   // Only the latched device's ready is ever observed.
   assign rdy_sel = |(sel_q & {timer_rdy, switch_rdy, dac_rdy, adc_rdy});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 1'b0;
         gnt_q    <= 1'b0;
         sel_q    <= '0;
         cs_q     <= '0;
         cs_cnt_q <= '0;
         to_cnt_q <= '0;
         ack0_q   <= 1'b0;
         done0_q  <= 1'b0;
         err0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         done1_q  <= 1'b0;
         err1_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (gnt_vld_d) begin
                  gnt_q  <= gnt_id_d;
                  sel_q  <= sel_d;
                  ptr_q  <= ptr_d;
                  busy_q <= 1'b1;
                  ack0_q <= ~gnt_id_d;
                  ack1_q <= gnt_id_d;
                  if (sel_d != 4'b0000) begin
                     cs_q     <= sel_d;
                     cs_cnt_q <= '0;
                     state_q  <= ST_CS;
                  end else begin
                     // Invalid code: ack and done land in the same cycle.
                     done0_q <= ~gnt_id_d;
                     done1_q <= gnt_id_d;
                     err0_q  <= ~gnt_id_d;
                     err1_q  <= gnt_id_d;
                     state_q <= ST_DONE;
                  end
               end
            end

            ST_CS: begin
               if (cs_cnt_q == CS_LAST) begin
                  cs_q    <= '0;
                  state_q <= ST_GUARD;
               end else begin
                  cs_cnt_q <= cs_cnt_q + 4'd1;
               end
            end

            ST_GUARD: begin
               to_cnt_q <= '0;
               state_q  <= ST_WAIT;
            end

            ST_WAIT: begin
               if (rdy_sel) begin
                  done0_q <= ~gnt_q;
                  done1_q <= gnt_q;
                  state_q <= ST_DONE;
               end else if (to_cnt_q == TO_LAST) begin
                  done0_q <= ~gnt_q;
                  done1_q <= gnt_q;
                  err0_q  <= ~gnt_q;
                  err1_q  <= gnt_q;
                  state_q <= ST_DONE;
               end else begin
                  to_cnt_q <= to_cnt_q + 16'd1;
               end
            end

            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               cs_q    <= '0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req0_ack  = ack0_q;
   assign req0_done = done0_q;
   assign req0_err  = err0_q;
   assign req1_ack  = ack1_q;
   assign req1_done = done1_q;
   assign req1_err  = err1_q;
   assign adc_cs    = cs_q[0];
   assign dac_cs    = cs_q[1];
   assign switch_cs = cs_q[2];
   assign timer_cs  = cs_q[3];
   assign busy      = busy_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: two instances (CS_WIDTH 1 and 4) against a transaction-timeline reference model.
// Output vector bit order: r0 ack/done/err, r1 ack/done/err, adc/dac/switch/timer cs, busy.

module tb_dev_bus_arbiter;

   localparam int unsigned CSW_A = 1;
   localparam int unsigned CSW_B = 4;
   localparam int unsigned TO    = 8;

   logic       clk;
   logic       rst;
   logic       v0, v1;
   logic [3:0] d0, d1;
   logic [3:0] rdy;
`ifdef ARB_LOCK_EN
   logic       lock;
`endif
   wire  [10:0] out_a;
   wire  [10:0] out_b;

   int n_chk, n_err;
   int cyc;
   bit chk_en;

   int          m_busy [2];
   int          m_id   [2];
   int          m_dev  [2];
   int          m_err  [2];
   int          m_g    [2];
   int          m_done [2];
   int          m_ptr  [2];
   logic [10:0] m_exp  [2];

   dev_bus_arbiter #(.CS_WIDTH(CSW_A), .TIMEOUT_CYCLES(TO)) u_dut_a (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_dev(d0),
`ifdef ARB_LOCK_EN
      .req0_lock(lock),
`endif
      .req0_ack(out_a[0]), .req0_done(out_a[1]), .req0_err(out_a[2]),
      .req1_valid(v1), .req1_dev(d1),
      .req1_ack(out_a[3]), .req1_done(out_a[4]), .req1_err(out_a[5]),
      .adc_cs(out_a[6]), .dac_cs(out_a[7]), .switch_cs(out_a[8]), .timer_cs(out_a[9]),
      .adc_rdy(rdy[0]), .dac_rdy(rdy[1]), .switch_rdy(rdy[2]), .timer_rdy(rdy[3]),
      .busy(out_a[10])
   );

   dev_bus_arbiter #(.CS_WIDTH(CSW_B), .TIMEOUT_CYCLES(TO)) u_dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_dev(d0),
`ifdef ARB_LOCK_EN
      .req0_lock(lock),
`endif
      .req0_ack(out_b[0]), .req0_done(out_b[1]), .req0_err(out_b[2]),
      .req1_valid(v1), .req1_dev(d1),
      .req1_ack(out_b[3]), .req1_done(out_b[4]), .req1_err(out_b[5]),
      .adc_cs(out_b[6]), .dac_cs(out_b[7]), .switch_cs(out_b[8]), .timer_cs(out_b[9]),
      .adc_rdy(rdy[0]), .dac_rdy(rdy[1]), .switch_rdy(rdy[2]), .timer_rdy(rdy[3]),
      .busy(out_b[10])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int csw(input int k);
      return (k == 0) ? int'(CSW_A) : int'(CSW_B);
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0;
         m_ptr[k]  = 0;
         m_done[k] = -1;
         m_g[k]    = 0;
         m_id[k]   = 0;
         m_dev[k]  = 0;
         m_err[k]  = 0;
         m_exp[k]  = '0;
      end
   endtask

   // Each transaction is a timeline from its grant edge g: cs for csw edges, guard,
   // then up to TO sampling edges, done reported on the edge that resolves it.
   task automatic m_step(input int k, input int e);
      int ws;
      int id;
      int dev;
      logic [10:0] o;
      if (m_busy[k] != 0) begin
         if (m_done[k] >= 0) begin
            if (e == m_done[k] + 1) m_busy[k] = 0;
         end else begin
            ws = m_g[k] + csw(k) + 2;
            if (e >= ws) begin
               if (rdy[m_dev[k] - 1]) begin
                  m_done[k] = e;
                  m_err[k]  = 0;
               end else if (e == ws + int'(TO) - 1) begin
                  m_done[k] = e;
                  m_err[k]  = 1;
               end
            end
         end
      end else if (v0 || v1) begin
         if (v0 && v1) id = m_ptr[k];
         else          id = v1 ? 1 : 0;
         dev       = (id == 1) ? int'(d1) : int'(d0);
         m_id[k]   = id;
         m_dev[k]  = dev;
         m_g[k]    = e;
         m_busy[k] = 1;
         m_ptr[k]  = 1 - id;
`ifdef ARB_LOCK_EN
         if (id == 0 && lock) m_ptr[k] = 0;
`endif
         if (dev >= 1 && dev <= 4) begin
            m_done[k] = -1;
            m_err[k]  = 0;
         end else begin
            m_done[k] = e;
            m_err[k]  = 1;
         end
      end

      o = '0;
      if (m_busy[k] != 0) begin
         o[10] = 1'b1;
         if (e == m_g[k]) o[3 * m_id[k]] = 1'b1;
         if (m_dev[k] >= 1 && m_dev[k] <= 4 && (e - m_g[k]) < csw(k)) o[5 + m_dev[k]] = 1'b1;
         if (e == m_done[k]) begin
            o[3 * m_id[k] + 1] = 1'b1;
            o[3 * m_id[k] + 2] = (m_err[k] != 0);
         end
      end
      m_exp[k] = o;
   endtask

   always @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) m_step(k, cyc);
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("outs_a", 32'(out_a), 32'(m_exp[0]));
         check_eq("outs_b", 32'(out_b), 32'(m_exp[1]));
      end
   end

   task automatic do_reset();
      #1;
      rst = 1'b1;
      m_reset();
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int done0_at;
      int ack1_at;
      int pulses;
      rst = 1'b0;
      v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; rdy = '0;
`ifdef ARB_LOCK_EN
      lock = 1'b0;
`endif
      n_chk = 0; n_err = 0; cyc = 0; chk_en = 1'b0;
      m_reset();
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check_eq("reset_outs_a", 32'(out_a), 32'h0);
      check_eq("reset_outs_b", 32'(out_b), 32'h0);
      #1 rst = 1'b0;

      // Single request, adc ready at once.
      @(negedge clk);
      rdy = 4'hF; v0 = 1'b1; d0 = 4'd1;
      @(negedge clk);
      check_eq("single_ack", 32'(out_a[0]), 32'h1);
      check_eq("single_adc_cs", 32'(out_a[9:6]), 32'h1);
      v0 = 1'b0;
      @(negedge clk);
      check_eq("single_cs_low", 32'(out_a[9:6]), 32'h0);
      @(negedge clk);
      @(negedge clk);
      check_eq("single_done_err", 32'(out_a[2:1]), 32'h1);
      repeat (10) @(negedge clk);

      // Tie after reset: req0 first, req1 two cycles after req0_done.
      do_reset();
      v0 = 1'b1; d0 = 4'd2; v1 = 1'b1; d1 = 4'd3; rdy = 4'hF;
      done0_at = -1; ack1_at = -1;
      for (int i = 0; i < 40 && ack1_at < 0; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check_eq("tie_first_dac_cs", 32'(out_a[7]), 32'h1);
            check_eq("tie_first_not_r1", 32'(out_a[3]), 32'h0);
         end
         if (out_a[0]) v0 = 1'b0;
         if (out_a[1] && done0_at < 0) done0_at = i;
         if (out_a[3]) begin
            ack1_at = i;
            v1 = 1'b0;
            check_eq("tie_second_switch_cs", 32'(out_a[8]), 32'h1);
         end
      end
      check_eq("tie_r1ack_gap", 32'(ack1_at - done0_at), 32'd2);
      v0 = 1'b0; v1 = 1'b0;
      repeat (12) @(negedge clk);

      // Timeout on the timer.
      rdy = 4'h0; v1 = 1'b1; d1 = 4'd4;
      @(negedge clk);
      v1 = 1'b0;
      pulses = int'(out_a[9]);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         pulses += int'(out_a[9]);
         if (i == 9) check_eq("timeout_not_early", 32'(out_a[4]), 32'h0);
      end
      check_eq("timeout_done_err", 32'(out_a[5:4]), 32'h3);
      check_eq("timeout_cs_pulses", 32'(pulses), 32'd1);
      repeat (8) @(negedge clk);

      // Invalid codes 0 and 7.
      d0 = 4'd0; v0 = 1'b1;
      @(negedge clk);
      check_eq("inv0_ack_done_err", 32'(out_a[2:0]), 32'h7);
      check_eq("inv0_no_cs", 32'(out_a[9:6]), 32'h0);
      v0 = 1'b0;
      @(negedge clk);
      d0 = 4'd7; v0 = 1'b1;
      @(negedge clk);
      check_eq("inv7_ack_done_err", 32'(out_a[2:0]), 32'h7);
      check_eq("inv7_no_cs", 32'(out_a[9:6]), 32'h0);
      v0 = 1'b0;
      repeat (4) @(negedge clk);

      // Asynchronous reset while dac_cs is high on the CS_WIDTH=4 instance.
      rdy = 4'h0; v0 = 1'b1; d0 = 4'd2;
      @(negedge clk);
      check_eq("rst_dac_cs_b", 32'(out_b[7]), 32'h1);
      v0 = 1'b0;
      @(posedge clk);
      #2;
      check_eq("rst_pre_dac_cs_b", 32'(out_b[7]), 32'h1);
      rst = 1'b1;
      m_reset();
      #1;
      check_eq("rst_async_cs_b", 32'(out_b[9:6]), 32'h0);
      check_eq("rst_async_busy_b", 32'(out_b[10]), 32'h0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      v0 = 1'b1; d0 = 4'd1; v1 = 1'b1; d1 = 4'd3; rdy = 4'hF;
      @(negedge clk);
      check_eq("post_rst_tie_a", 32'(out_a[3:0] & 4'b1001), 32'h1);
      check_eq("post_rst_tie_b", 32'(out_b[3:0] & 4'b1001), 32'h1);
      v0 = 1'b0;
      repeat (10) @(negedge clk);
      v1 = 1'b0;
      repeat (10) @(negedge clk);

`ifdef ARB_LOCK_EN
      begin
         int seq [4];
         int n_a;
         do_reset();
         seq = '{-1, -1, -1, -1};
         n_a = 0;
         lock = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'd1; d1 = 4'd2; rdy = 4'hF;
         for (int i = 0; i < 80 && n_a < 4; i++) begin
            @(negedge clk);
            if (out_a[0]) begin
               seq[n_a] = 0;
               n_a++;
               if (n_a == 2) lock = 1'b0;
            end else if (out_a[3]) begin
               seq[n_a] = 1;
               n_a++;
            end
         end
         check_eq("lock_grant0", 32'(seq[0]), 32'd0);
         check_eq("lock_grant1", 32'(seq[1]), 32'd0);
         check_eq("lock_grant2", 32'(seq[2]), 32'd0);
         check_eq("lock_grant3", 32'(seq[3]), 32'd1);
         v0 = 1'b0; v1 = 1'b0; lock = 1'b0;
         repeat (12) @(negedge clk);
      end
`endif

      // Randomized traffic: toggling/withdrawn requests, changing codes, sparse ready.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) v0 = ~v0;
         if ($urandom_range(0, 3) == 0) v1 = ~v1;
         if ($urandom_range(0, 2) == 0) d0 = 4'($urandom_range(0, 5));
         if ($urandom_range(0, 2) == 0) d1 = 4'($urandom_range(0, 5));
         if ($urandom_range(0, 40) == 0) d1 = 4'($urandom_range(6, 15));
         rdy = 4'($urandom & $urandom);
`ifdef ARB_LOCK_EN
         if ($urandom_range(0, 5) == 0) lock = ~lock;
`endif
      end
      v0 = 1'b0; v1 = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
